// File: rtl/calendar_date_counter.sv
// BCD calendar: day/month/year plus day-of-week, stepped one day per tick in either
// direction, with Gregorian leap handling and a validated parallel load.
module calendar_date_counter #(
    parameter int          YEAR_DIGITS    = 4,
    parameter logic [15:0] START_YEAR     = 16'h2000,
    parameter logic [2:0]  START_DOW      = 3'd6,
    parameter bit          FULL_GREGORIAN = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tick,
    input  logic                     stay,
    input  logic                     dir,
    input  logic                     load,
    input  logic [7:0]               load_day,
    input  logic [7:0]               load_month,
    input  logic [4*YEAR_DIGITS-1:0] load_year,
    input  logic [2:0]               load_dow,
    output logic [7:0]               day_bcd,
    output logic [7:0]               month_bcd,
    output logic [4*YEAR_DIGITS-1:0] year_bcd,
    output logic [2:0]               dow,
    output logic                     leap,
    output logic                     month_wrap,
    output logic                     year_wrap,
    output logic                     load_err
);

    localparam int YW           = 4 * YEAR_DIGITS;
    localparam bit CENTURY_RULE = FULL_GREGORIAN && (YEAR_DIGITS == 4);

    // Divisibility by 4 of a two-digit BCD number, decided from the digits alone.
    function automatic logic div4(input logic [7:0] pair);
        if (pair[4])
            return (pair[3:0] == 4'd2) || (pair[3:0] == 4'd6);
        else
            return (pair[3:0] == 4'd0) || (pair[3:0] == 4'd4) || (pair[3:0] == 4'd8);
    endfunction

    function automatic logic leapOf(input logic [YW-1:0] y);
        logic [15:0] yp;
        yp = 16'(y);
        if (CENTURY_RULE && (yp[7:0] == 8'h00))
            return div4(yp[15:8]);
        else
            return div4(yp[7:0]);
    endfunction

    function automatic logic [7:0] monthLen(input logic [7:0] m, input logic lp);
        case (m)
            8'h02:                      return lp ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
            default:                    return 8'h31;
        endcase
    endfunction

    function automatic logic [7:0] bcdInc2(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcdDec2(input logic [7:0] v);
        if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        else
            return {v[7:4], v[3:0] - 4'd1};
    endfunction

    function automatic logic bcd2Ok(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    logic [7:0]    dayReg, monthReg, dayNext, monthNext;
    logic [YW-1:0] yearReg, yearNext, yearInc, yearDec;
    logic [2:0]    dowReg, dowNext;
    logic          monthWrapReg, yearWrapReg, loadErrReg;
    logic          monthWrapNext, yearWrapNext;
    logic          leapCur, loadOk;
    logic [7:0]    curLen, prevMonth;

    logic [YEAR_DIGITS-1:0] incCarry, decBorrow, loadDigitOk;

    assign incCarry[0]  = 1'b1;
    assign decBorrow[0] = 1'b1;

    // Year ripple increment/decrement and per-digit load check.
    generate
        for (genvar gi = 0; gi < YEAR_DIGITS; gi++) begin : genYearDigit
            logic [3:0] digit;
            assign digit = yearReg[4*gi +: 4];
            assign yearInc[4*gi +: 4] = !incCarry[gi] ? digit :
                                        (digit == 4'd9) ? 4'd0 : digit + 4'd1;
            assign yearDec[4*gi +: 4] = !decBorrow[gi] ? digit :
                                        (digit == 4'd0) ? 4'd9 : digit - 4'd1;
            assign loadDigitOk[gi] = (load_year[4*gi +: 4] <= 4'd9);
            if (gi < YEAR_DIGITS - 1) begin : genChain
                assign incCarry[gi+1]  = incCarry[gi]  && (digit == 4'd9);
                assign decBorrow[gi+1] = decBorrow[gi] && (digit == 4'd0);
            end
        end
    endgenerate

    assign leapCur   = leapOf(yearReg);
    assign curLen    = monthLen(monthReg, leapCur);
    assign prevMonth = bcdDec2(monthReg);

    assign loadOk = bcd2Ok(load_day) && bcd2Ok(load_month) && (&loadDigitOk)
                 && (load_month >= 8'h01) && (load_month <= 8'h12)
                 && (load_day >= 8'h01)
                 && (load_day <= monthLen(load_month, leapOf(load_year)))
                 && (load_dow <= 3'd6);

    always_comb begin
        dayNext       = dayReg;
        monthNext     = monthReg;
        yearNext      = yearReg;
        dowNext       = dowReg;
        monthWrapNext = 1'b0;
        yearWrapNext  = 1'b0;
        if (!dir) begin
            dowNext = (dowReg == 3'd6) ? 3'd0 : dowReg + 3'd1;
            if (dayReg < curLen) begin
                dayNext = bcdInc2(dayReg);
            end else begin
                dayNext       = 8'h01;
                monthWrapNext = 1'b1;
                if (monthReg == 8'h12) begin
                    monthNext    = 8'h01;
                    yearNext     = yearInc;
                    yearWrapNext = 1'b1;
                end else begin
                    monthNext = bcdInc2(monthReg);
                end
            end
        end else begin
            dowNext = (dowReg == 3'd0) ? 3'd6 : dowReg - 3'd1;
            if (dayReg > 8'h01) begin
                dayNext = bcdDec2(dayReg);
            end else begin
                monthWrapNext = 1'b1;
                // Stepping back into December always lands on day 31, whatever the year.
                if (monthReg == 8'h01) begin
                    monthNext    = 8'h12;
                    dayNext      = 8'h31;
                    yearNext     = yearDec;
                    yearWrapNext = 1'b1;
                end else begin
                    monthNext = prevMonth;
                    dayNext   = monthLen(prevMonth, leapCur);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dayReg       <= 8'h01;
            monthReg     <= 8'h01;
            yearReg      <= START_YEAR[YW-1:0];
            dowReg       <= START_DOW;
            monthWrapReg <= 1'b0;
            yearWrapReg  <= 1'b0;
            loadErrReg   <= 1'b0;
        end else begin
            monthWrapReg <= 1'b0;
            yearWrapReg  <= 1'b0;
            loadErrReg   <= 1'b0;
            if (load) begin
                if (loadOk) begin
                    dayReg   <= load_day;
                    monthReg <= load_month;
                    yearReg  <= load_year;
                    dowReg   <= load_dow;
                end else begin
                    loadErrReg <= 1'b1;
                end
            end else if (tick && stay) begin
                dayReg       <= dayNext;
                monthReg     <= monthNext;
                yearReg      <= yearNext;
                dowReg       <= dowNext;
                monthWrapReg <= monthWrapNext;
                yearWrapReg  <= yearWrapNext;
            end
        end
    end

    assign day_bcd    = dayReg;
    assign month_bcd  = monthReg;
    assign year_bcd   = yearReg;
    assign dow        = dowReg;
    assign leap       = leapCur;
    assign month_wrap = monthWrapReg;
    assign year_wrap  = yearWrapReg;
    assign load_err   = loadErrReg;

endmodule

// File: tb/tb_calendar_date_counter.sv
// Scoreboard bench for calendar_date_counter: directed vectors push expected dates,
// a monitor pops and compares one cycle after each issued operation.
module tb_calendar_date_counter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick = 1'b0, stay = 1'b0, dir = 1'b0, load = 1'b0;
    logic [7:0]  load_day = 8'h01, load_month = 8'h01;
    logic [15:0] load_year = 16'h2000;
    logic [2:0]  load_dow = 3'd0;

    logic [7:0]  dayBcd, monthBcd, altDay, altMonth;
    logic [15:0] yearBcd, altYear;
    logic [2:0]  dowOut, altDow;
    logic        leapOut, monthWrap, yearWrap, loadErr;
    logic        altLeap, altMonthWrap, altYearWrap, altLoadErr;

    calendar_date_counter #(.YEAR_DIGITS(4), .START_YEAR(16'h2000), .START_DOW(3'd6),
                            .FULL_GREGORIAN(1'b1)) dut (
        .clk(clk), .rst(rst), .tick(tick), .stay(stay), .dir(dir), .load(load),
        .load_day(load_day), .load_month(load_month), .load_year(load_year),
        .load_dow(load_dow), .day_bcd(dayBcd), .month_bcd(monthBcd), .year_bcd(yearBcd),
        .dow(dowOut), .leap(leapOut), .month_wrap(monthWrap), .year_wrap(yearWrap),
        .load_err(loadErr)
    );

    // Same stimulus, simple every-fourth-year leap rule.
    calendar_date_counter #(.YEAR_DIGITS(4), .START_YEAR(16'h2000), .START_DOW(3'd6),
                            .FULL_GREGORIAN(1'b0)) dutJulian (
        .clk(clk), .rst(rst), .tick(tick), .stay(stay), .dir(dir), .load(load),
        .load_day(load_day), .load_month(load_month), .load_year(load_year),
        .load_dow(load_dow), .day_bcd(altDay), .month_bcd(altMonth), .year_bcd(altYear),
        .dow(altDow), .leap(altLeap), .month_wrap(altMonthWrap), .year_wrap(altYearWrap),
        .load_err(altLoadErr)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [38:0] val;   // {day, month, year, dow, leap, month_wrap, year_wrap, load_err}
    } exp_t;

    exp_t        expQ[$];
    exp_t        monE;
    logic [38:0] monAct;
    logic        issue = 1'b0;
    int          vecCount = 0;
    int          missCount = 0;

    task automatic report(input string name, input logic [38:0] act, input logic [38:0] want);
        vecCount++;
        if (act !== want) begin
            missCount++;
            $display("FAIL %s: got %h/%h/%h dow=%0d lp=%b mw=%b yw=%b le=%b, want %h/%h/%h dow=%0d lp=%b mw=%b yw=%b le=%b",
                     name, act[38:31], act[30:23], act[22:7], act[6:4], act[3], act[2], act[1], act[0],
                     want[38:31], want[30:23], want[22:7], want[6:4], want[3], want[2], want[1], want[0]);
        end else begin
            $display("ok   %s: %h/%h/%h dow=%0d lp=%b mw=%b yw=%b le=%b",
                     name, act[38:31], act[30:23], act[22:7], act[6:4], act[3], act[2], act[1], act[0]);
        end
    endtask

    // Monitor: every issued operation yields one observation just after the edge.
    always @(posedge clk) begin
        if (issue) begin
            #1;
            monAct = {dayBcd, monthBcd, yearBcd, dowOut, leapOut, monthWrap, yearWrap, loadErr};
            if (expQ.size() == 0) begin
                vecCount++;
                missCount++;
                $display("FAIL orphan: DUT output %h with no expected entry", monAct);
            end else begin
                monE = expQ.pop_front();
                report(monE.name, monAct, monE.val);
            end
        end
    end

    task automatic issueOp(input string name, input logic tk, input logic st, input logic dr,
                           input logic ld, input logic [7:0] lDay, input logic [7:0] lMon,
                           input logic [15:0] lYear, input logic [2:0] lDow,
                           input logic [7:0] eDay, input logic [7:0] eMon, input logic [15:0] eYear,
                           input logic [2:0] eDow, input logic eLeap, input logic [2:0] ePulse);
        exp_t e;
        @(negedge clk);
        tick       = tk;
        stay       = st;
        dir        = dr;
        load       = ld;
        load_day   = lDay;
        load_month = lMon;
        load_year  = lYear;
        load_dow   = lDow;
        issue      = 1'b1;
        e.name = name;
        e.val  = {eDay, eMon, eYear, eDow, eLeap, ePulse};
        expQ.push_back(e);
    endtask

    task automatic tickOp(input string name, input logic st, input logic dr,
                          input logic [7:0] eDay, input logic [7:0] eMon, input logic [15:0] eYear,
                          input logic [2:0] eDow, input logic eLeap, input logic [2:0] ePulse);
        issueOp(name, 1'b1, st, dr, 1'b0, 8'h01, 8'h01, 16'h2000, 3'd0,
                eDay, eMon, eYear, eDow, eLeap, ePulse);
    endtask

    task automatic holdOp(input string name,
                          input logic [7:0] eDay, input logic [7:0] eMon, input logic [15:0] eYear,
                          input logic [2:0] eDow, input logic eLeap, input logic [2:0] ePulse);
        issueOp(name, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 8'h01, 16'h2000, 3'd0,
                eDay, eMon, eYear, eDow, eLeap, ePulse);
    endtask

    task automatic loadOp(input string name, input logic tk,
                          input logic [7:0] lDay, input logic [7:0] lMon, input logic [15:0] lYear,
                          input logic [2:0] lDow,
                          input logic [7:0] eDay, input logic [7:0] eMon, input logic [15:0] eYear,
                          input logic [2:0] eDow, input logic eLeap, input logic [2:0] ePulse);
        issueOp(name, tk, 1'b1, 1'b0, 1'b1, lDay, lMon, lYear, lDow,
                eDay, eMon, eYear, eDow, eLeap, ePulse);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        repeat (2) @(negedge clk);
        report("reset", {dayBcd, monthBcd, yearBcd, dowOut, leapOut, monthWrap, yearWrap, loadErr},
               {8'h01, 8'h01, 16'h2000, 3'd6, 1'b1, 3'b000});
        rst = 1'b1;

        holdOp("hold_start", 8'h01, 8'h01, 16'h2000, 3'd6, 1'b1, 3'b000);
        loadOp("ld_0228_2023", 1'b0, 8'h28, 8'h02, 16'h2023, 3'd2, 8'h28, 8'h02, 16'h2023, 3'd2, 1'b0, 3'b000);
        tickOp("fwd_feb_2023", 1'b1, 1'b0, 8'h01, 8'h03, 16'h2023, 3'd3, 1'b0, 3'b100);
        holdOp("pulse_clears", 8'h01, 8'h03, 16'h2023, 3'd3, 1'b0, 3'b000);
        loadOp("ld_0228_2024", 1'b0, 8'h28, 8'h02, 16'h2024, 3'd3, 8'h28, 8'h02, 16'h2024, 3'd3, 1'b1, 3'b000);
        tickOp("fwd_leap_2024", 1'b1, 1'b0, 8'h29, 8'h02, 16'h2024, 3'd4, 1'b1, 3'b000);
        tickOp("fwd_0229_2024", 1'b1, 1'b0, 8'h01, 8'h03, 16'h2024, 3'd5, 1'b1, 3'b100);
        tickOp("back_0301_2024", 1'b1, 1'b1, 8'h29, 8'h02, 16'h2024, 3'd4, 1'b1, 3'b100);
        loadOp("ld_0228_2000", 1'b0, 8'h28, 8'h02, 16'h2000, 3'd1, 8'h28, 8'h02, 16'h2000, 3'd1, 1'b1, 3'b000);
        tickOp("fwd_leap_2000", 1'b1, 1'b0, 8'h29, 8'h02, 16'h2000, 3'd2, 1'b1, 3'b000);
        loadOp("ld_1231_9999", 1'b0, 8'h31, 8'h12, 16'h9999, 3'd5, 8'h31, 8'h12, 16'h9999, 3'd5, 1'b0, 3'b000);
        tickOp("fwd_9999_wrap", 1'b1, 1'b0, 8'h01, 8'h01, 16'h0000, 3'd6, 1'b1, 3'b110);

        // Asynchronous reset while both wrap pulses are high, checked before any edge.
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        report("reset_async", {dayBcd, monthBcd, yearBcd, dowOut, leapOut, monthWrap, yearWrap, loadErr},
               {8'h01, 8'h01, 16'h2000, 3'd6, 1'b1, 3'b000});
        @(negedge clk);
        tick  = 1'b0;
        load  = 1'b0;
        issue = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        holdOp("after_reset", 8'h01, 8'h01, 16'h2000, 3'd6, 1'b1, 3'b000);
        tickOp("stay0_fwd", 1'b0, 1'b0, 8'h01, 8'h01, 16'h2000, 3'd6, 1'b1, 3'b000);
        tickOp("stay0_back", 1'b0, 1'b1, 8'h01, 8'h01, 16'h2000, 3'd6, 1'b1, 3'b000);
        tickOp("back_2000", 1'b1, 1'b1, 8'h31, 8'h12, 16'h1999, 3'd5, 1'b0, 3'b110);
        tickOp("fwd_1999", 1'b1, 1'b0, 8'h01, 8'h01, 16'h2000, 3'd6, 1'b1, 3'b110);
        loadOp("ld_0101_0000", 1'b0, 8'h01, 8'h01, 16'h0000, 3'd6, 8'h01, 8'h01, 16'h0000, 3'd6, 1'b1, 3'b000);
        tickOp("back_0000_wrap", 1'b1, 1'b1, 8'h31, 8'h12, 16'h9999, 3'd5, 1'b0, 3'b110);

        loadOp("rej_0431", 1'b0, 8'h31, 8'h04, 16'h2023, 3'd0, 8'h31, 8'h12, 16'h9999, 3'd5, 1'b0, 3'b001);
        loadOp("rej_0229_2023", 1'b0, 8'h29, 8'h02, 16'h2023, 3'd3, 8'h31, 8'h12, 16'h9999, 3'd5, 1'b0, 3'b001);
        loadOp("rej_day_nibble", 1'b0, 8'h0A, 8'h01, 16'h2023, 3'd0, 8'h31, 8'h12, 16'h9999, 3'd5, 1'b0, 3'b001);
        loadOp("rej_year_nibble", 1'b0, 8'h15, 8'h03, 16'h202A, 3'd0, 8'h31, 8'h12, 16'h9999, 3'd5, 1'b0, 3'b001);
        loadOp("rej_dow7", 1'b0, 8'h01, 8'h01, 16'h2023, 3'd7, 8'h31, 8'h12, 16'h9999, 3'd5, 1'b0, 3'b001);
        holdOp("err_clears", 8'h31, 8'h12, 16'h9999, 3'd5, 1'b0, 3'b000);

        loadOp("load_beats_tick", 1'b1, 8'h15, 8'h06, 16'h2023, 3'd4, 8'h15, 8'h06, 16'h2023, 3'd4, 1'b0, 3'b000);
        tickOp("b2b_1", 1'b1, 1'b0, 8'h16, 8'h06, 16'h2023, 3'd5, 1'b0, 3'b000);
        tickOp("b2b_2", 1'b1, 1'b0, 8'h17, 8'h06, 16'h2023, 3'd6, 1'b0, 3'b000);
        tickOp("b2b_dow_wrap", 1'b1, 1'b0, 8'h18, 8'h06, 16'h2023, 3'd0, 1'b0, 3'b000);
        tickOp("b2b_back", 1'b1, 1'b1, 8'h17, 8'h06, 16'h2023, 3'd6, 1'b0, 3'b000);
        loadOp("ld_0919_2023", 1'b0, 8'h19, 8'h09, 16'h2023, 3'd2, 8'h19, 8'h09, 16'h2023, 3'd2, 1'b0, 3'b000);
        tickOp("fwd_day_carry", 1'b1, 1'b0, 8'h20, 8'h09, 16'h2023, 3'd3, 1'b0, 3'b000);
        tickOp("back_day_borrow", 1'b1, 1'b1, 8'h19, 8'h09, 16'h2023, 3'd2, 1'b0, 3'b000);
        loadOp("ld_0930_2023", 1'b0, 8'h30, 8'h09, 16'h2023, 3'd6, 8'h30, 8'h09, 16'h2023, 3'd6, 1'b0, 3'b000);
        tickOp("fwd_month_carry", 1'b1, 1'b0, 8'h01, 8'h10, 16'h2023, 3'd0, 1'b0, 3'b100);
        tickOp("back_month_borrow", 1'b1, 1'b1, 8'h30, 8'h09, 16'h2023, 3'd6, 1'b0, 3'b100);
        loadOp("ld_0430_2023", 1'b0, 8'h30, 8'h04, 16'h2023, 3'd0, 8'h30, 8'h04, 16'h2023, 3'd0, 1'b0, 3'b000);
        tickOp("fwd_apr30", 1'b1, 1'b0, 8'h01, 8'h05, 16'h2023, 3'd1, 1'b0, 3'b100);
        tickOp("back_may01", 1'b1, 1'b1, 8'h30, 8'h04, 16'h2023, 3'd0, 1'b0, 3'b100);

        loadOp("ld_0228_2100", 1'b0, 8'h28, 8'h02, 16'h2100, 3'd0, 8'h28, 8'h02, 16'h2100, 3'd0, 1'b0, 3'b000);
        tickOp("fwd_2100_century", 1'b1, 1'b0, 8'h01, 8'h03, 16'h2100, 3'd1, 1'b0, 3'b100);
        @(posedge clk);
        #1;
        report("julian_2100", {altDay, altMonth, altYear, altDow, altLeap, altMonthWrap, altYearWrap, altLoadErr},
               {8'h29, 8'h02, 16'h2100, 3'd1, 1'b1, 3'b000});
        loadOp("rej_0229_2100", 1'b0, 8'h29, 8'h02, 16'h2100, 3'd2, 8'h01, 8'h03, 16'h2100, 3'd1, 1'b0, 3'b001);
        holdOp("hold_end", 8'h01, 8'h03, 16'h2100, 3'd1, 1'b0, 3'b000);

        @(negedge clk);
        tick  = 1'b0;
        load  = 1'b0;
        issue = 1'b0;
        repeat (3) @(negedge clk);
        vecCount++;
        if (expQ.size() != 0) begin
            missCount++;
            $display("FAIL drain: %0d expected entries left, want 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/calendar_date_counter.md
Name: calendar_date_counter

Overview:
- Parametrised BCD calendar (day/month/year + day-of-week), replacing the per-digit date counters in the clock/calendar chain.
- Advances one day per `tick` from the time-of-day chain, at its 23:59:59.99 rollover.
- Adds behaviour the per-digit counters lack: full Gregorian leap rules, configurable year width, backward stepping for button setting, and validated parallel load.

Parameters:
- YEAR_DIGITS, 4, BCD digits of year; legal values 2 or 4.
- START_YEAR, 16'h2000, BCD reset year (low 4*YEAR_DIGITS bits used).
- START_DOW, 6, reset day-of-week (0=Sunday .. 6=Saturday); 6 matches 2000-01-01.
- FULL_GREGORIAN, 1, 1: century rule applied (YEAR_DIGITS=4 only); 0: every year divisible by 4 is leap.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-low
- tick  in  1  one-cycle day-advance pulse
- stay  in  1  run enable; tick ignored when 0
- dir  in  1  0: step forward, 1: step backward
- load  in  1  one-cycle parallel load strobe
- load_day  in  8  BCD day 01..31
- load_month  in  8  BCD month 01..12
- load_year  in  4*YEAR_DIGITS  BCD year
- load_dow  in  3  day-of-week to load, 0..6
- day_bcd  out  8  BCD day, 1-based
- month_bcd  out  8  BCD month, 1-based
- year_bcd  out  4*YEAR_DIGITS  BCD year
- dow  out  3  day-of-week 0..6
- leap  out  1  current year is leap (combinational from year_bcd)
- month_wrap  out  1  one-cycle pulse on month change by tick
- year_wrap  out  1  one-cycle pulse on year change by tick
- load_err  out  1  one-cycle pulse on rejected load

Behaviour:
Reset:
- rst low asynchronously sets day_bcd=8'h01, month_bcd=8'h01, year_bcd=START_YEAR, dow=START_DOW, and all pulses 0.
- Release is synchronous to the next clk edge.

Priority per cycle:
- load > (tick & stay) > hold.
- load with tick in the same cycle: load wins; tick is dropped.

Load validation:
- All fields must be valid BCD (each nibble <= 9).
- Month 01..12; day 01..month length for the loaded year's leap status; load_dow <= 6.
- Valid: registers take the new values next edge, no wrap pulses.
- Invalid: state unchanged; load_err=1 for one cycle.

Month length:
- 31 for months 01, 03, 05, 07, 08, 10, 12.
- 30 for months 04, 06, 09, 11.
- February: 29 if leap, else 28.

Leap rule (low two BCD digits yy):
- Divisible by 4 iff (tens even and units in {0,4,8}) or (tens odd and units in {2,6}).
- If yy==00, YEAR_DIGITS=4 and FULL_GREGORIAN=1: leap iff the century pair is divisible by 4, same digit test.
- Otherwise leap iff yy divisible by 4.

Forward step (dir=0), latency one cycle:
- day < month length: day+1.
- Else day=01 and month+1 with month_wrap=1.
- Month 12 rolls to 01 with year+1 (BCD ripple, every digit 9->0 carries) and year_wrap=1.
- All-nines year wraps to all-zeros; year_wrap=1.
- dow = (dow+1) mod 7.

Backward step (dir=1):
- day > 01: day-1.
- Else month-1, day = length of the new month, month_wrap=1.
- Month 01 goes to 12, year-1 (BCD borrow ripple), year_wrap=1; all-zeros year wraps to all-nines.
- dow = (dow+6) mod 7.
- Length of the new month uses the leap status of the resulting year.

Other:
- Wrap pulses are registered, high exactly one cycle, and never asserted on load or reset.
- Registers never hold a non-BCD or out-of-range value.
- Reset asserted mid-step overrides everything; no pulse may survive reset.
- Consecutive ticks on back-to-back cycles must each step once; no internal state beyond the outputs.

Test Plan:
- Reset: rst low during activity -> 01/01/2000, dow=6, pulses 0 immediately, without a clk edge.
- Leap forward: load 28/02/2023, tick -> 01/03/2023, month_wrap=1. Load 28/02/2024, tick -> 29/02/2024, leap=1; tick -> 01/03/2024.
- Century rule: load 28/02/2100, tick -> 01/03/2100 (leap=0). Load 28/02/2000, tick -> 29/02/2000. FULL_GREGORIAN=0: 2100 gives 29/02.
- Year rollover and stay: load 31/12/9999 dow=5, tick -> 01/01/0000, dow=6, month_wrap=year_wrap=1. With stay=0, ticks leave the date unchanged.
- Backward: dir=1 from 01/03/2024 -> 29/02/2024. From 01/01/2000 -> 31/12/1999, year_wrap=1, dow=5. From 01/01/0000 -> 31/12/9999.
- Load validation: 31/04/2023 -> rejected, load_err pulse, state unchanged. 29/02/2023 -> rejected. Nibble 4'hA -> rejected. Load and tick in the same cycle -> loaded value, no step.
